// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Constants shared by the memory/writeback stage of the pipelined MIPS core:
// pipeline address/data widths, the data memory depth, the reset value of the
// M/W pipeline register, and the word-alignment mask for data accesses.
// -----------------------------------------------------------------------------
package pipeline_pkg;

  // Address width of the pipeline; the data memory is indexed by
  // ALUOutM[AWL+1:2], so it holds 2**AWL words.
  localparam int AWL   = 6;
  localparam int DWL   = 32;
  localparam int DEPTH = 2 ** AWL;

  // Every field of the W register resets to this bit value.
  localparam logic W_RESET_BIT = 1'b0;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  // True when a byte address does not point at a word boundary.
  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return (byte_offset & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage : pipeline_pkg

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// DEPTH x DWL word-addressed data memory: synchronous write, asynchronous
// read. The read port sees the contents before any write on the same edge,
// so a simultaneous store and load of one word returns the old data.
//
// Ports:
//   clk    in   write clock, rising edge
//   we     in   write enable
//   addr   in   [AWL-1:0] word index, shared by read and write
//   wdata  in   [DWL-1:0] write data
//   rdata  out  [DWL-1:0] combinational read data at addr
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int AWL   = 6,
  parameter int DWL   = 32,
  parameter int DEPTH = 2 ** AWL
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AWL-1:0] addr,
  input  logic [DWL-1:0] wdata,
  output logic [DWL-1:0] rdata
);

  logic [DWL-1:0] mem [DEPTH];

  // NOTE: the array has no reset; resetting a RAM prevents mapping it onto
  // memory macros and costs a write port per word. Software must write a
  // location before reading it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : data_memory

// File: rtl/memory_writeback.sv
// -----------------------------------------------------------------------------
// memory_writeback
// Memory and writeback stage of the pipelined MIPS core. Performs loads and
// stores against the data memory during M, registers the results into the
// M/W pipeline register, and drives the writeback data/enable/destination
// to the register file and to the Execute forwarding muxes. Misaligned
// accesses are suppressed (no memory write, no register-file write) and
// latch the sticky DMErr flag.
//
// Optional feature (macro DM_ACCESS_CNT_EN): saturating counters of aligned
// loads and stores on LoadCnt / StoreCnt. Without the macro those ports and
// their logic do not exist.
//
// Ports:
//   CLK        in   pipeline clock, rising edge
//   RSTn       in   asynchronous active-low reset
//   RFWEM      in   register-file write enable from M
//   MtoRFSelM  in   1 = writeback selects memory data, 0 = ALU result
//   DMWEM      in   data memory write enable (store)
//   ALUOutM    in   [DWL-1:0] byte address for loads/stores, or ALU result
//   DMdinM     in   [DWL-1:0] store data
//   RFAM       in   [AWL-2:0] destination register
//   ResultW    out  [DWL-1:0] writeback data
//   RFWEW      out  writeback enable
//   RFAW       out  [AWL-2:0] writeback destination
//   DMErr      out  sticky misaligned-access flag
//   LoadCnt    out  [DWL-1:0] aligned load count   (DM_ACCESS_CNT_EN only)
//   StoreCnt   out  [DWL-1:0] aligned store count  (DM_ACCESS_CNT_EN only)
// -----------------------------------------------------------------------------
module memory_writeback
  import pipeline_pkg::*;
#(
  parameter int AWL = pipeline_pkg::AWL,
  parameter int DWL = pipeline_pkg::DWL
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           RFWEM,
  input  logic           MtoRFSelM,
  input  logic           DMWEM,
  input  logic [DWL-1:0] ALUOutM,
  input  logic [DWL-1:0] DMdinM,
  input  logic [AWL-2:0] RFAM,
  output logic [DWL-1:0] ResultW,
  output logic           RFWEW,
  output logic [AWL-2:0] RFAW,
  output logic           DMErr
`ifdef DM_ACCESS_CNT_EN
  ,
  output logic [DWL-1:0] LoadCnt,
  output logic [DWL-1:0] StoreCnt
`endif
);

  localparam int MEM_DEPTH = 2 ** AWL;

  // ---------------------------------------------------------------------------
  // M-stage access decode
  // ---------------------------------------------------------------------------
  logic [AWL-1:0] word_idx;
  logic           misaligned;
  logic           load_ok;
  logic           store_ok;
  logic           access_err;
  logic           load_err;
  logic [DWL-1:0] read_data_m;

  // Upper address bits are dropped, so addresses wrap modulo the depth.
  assign word_idx   = ALUOutM[AWL+1:2];
  assign misaligned = is_misaligned(ALUOutM[1:0]);

  assign load_ok    = MtoRFSelM & ~misaligned;
  assign store_ok   = DMWEM & ~misaligned;
  assign load_err   = MtoRFSelM & misaligned;
  assign access_err = (MtoRFSelM | DMWEM) & misaligned;

  data_memory #(
    .AWL   (AWL),
    .DWL   (DWL),
    .DEPTH (MEM_DEPTH)
  ) u_data_memory (
    .clk   (CLK),
    .we    (store_ok),
    .addr  (word_idx),
    .wdata (DMdinM),
    .rdata (read_data_m)
  );

  // ---------------------------------------------------------------------------
  // M/W pipeline register
  // ---------------------------------------------------------------------------
  logic           rfwe_w;
  logic           mtorfsel_w;
  logic [DWL-1:0] alu_out_w;
  logic [DWL-1:0] read_data_w;
  logic [AWL-2:0] rfa_w;
  logic           dm_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rfwe_w      <= W_RESET_BIT;
      mtorfsel_w  <= W_RESET_BIT;
      alu_out_w   <= {DWL{W_RESET_BIT}};
      read_data_w <= {DWL{W_RESET_BIT}};
      rfa_w       <= {(AWL-1){W_RESET_BIT}};
      dm_err_q    <= 1'b0;
    end else begin
      // A misaligned load must not update the register file.
      rfwe_w      <= RFWEM & ~load_err;
      mtorfsel_w  <= MtoRFSelM;
      alu_out_w   <= ALUOutM;
      // Only an aligned load captures memory data; this also keeps
      // never-written words from leaking into the W register.
      read_data_w <= load_ok ? read_data_m : '0;
      rfa_w       <= RFAM;
      dm_err_q    <= dm_err_q | access_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback mux
  // ---------------------------------------------------------------------------
  assign ResultW = mtorfsel_w ? read_data_w : alu_out_w;
  assign RFWEW   = rfwe_w;
  assign RFAW    = rfa_w;
  assign DMErr   = dm_err_q;

  // ---------------------------------------------------------------------------
  // Optional access counters
  // ---------------------------------------------------------------------------
`ifdef DM_ACCESS_CNT_EN
  logic [DWL-1:0] load_cnt_q;
  logic [DWL-1:0] store_cnt_q;

  // Counters stop at all-ones rather than wrapping back to zero.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (load_ok && (load_cnt_q != '1)) begin
        load_cnt_q <= load_cnt_q + DWL'(1);
      end
      if (store_ok && (store_cnt_q != '1)) begin
        store_cnt_q <= store_cnt_q + DWL'(1);
      end
    end
  end

  assign LoadCnt  = load_cnt_q;
  assign StoreCnt = store_cnt_q;
`endif

endmodule : memory_writeback

// File: tb/tb_memory_writeback.sv
// -----------------------------------------------------------------------------
// tb_memory_writeback
// Scoreboard bench for memory_writeback. Each directed M-stage vector carries
// its hand-computed W-stage response; the stimulus pushes it into a queue
// tagged with the cycle in which it must appear, and an independent monitor
// pops and compares on the falling edge. Reset behaviour and the optional
// access counters are checked directly.
// -----------------------------------------------------------------------------
module tb_memory_writeback;

  localparam int AWL = 6;
  localparam int DWL = 32;

  logic           CLK;
  logic           RSTn;
  logic           RFWEM;
  logic           MtoRFSelM;
  logic           DMWEM;
  logic [DWL-1:0] ALUOutM;
  logic [DWL-1:0] DMdinM;
  logic [AWL-2:0] RFAM;
  logic [DWL-1:0] ResultW;
  logic           RFWEW;
  logic [AWL-2:0] RFAW;
  logic           DMErr;
`ifdef DM_ACCESS_CNT_EN
  logic [DWL-1:0] LoadCnt;
  logic [DWL-1:0] StoreCnt;
`endif

  memory_writeback #(
    .AWL (AWL),
    .DWL (DWL)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .RFWEM     (RFWEM),
    .MtoRFSelM (MtoRFSelM),
    .DMWEM     (DMWEM),
    .ALUOutM   (ALUOutM),
    .DMdinM    (DMdinM),
    .RFAM      (RFAM),
    .ResultW   (ResultW),
    .RFWEW     (RFWEW),
    .RFAW      (RFAW),
    .DMErr     (DMErr)
`ifdef DM_ACCESS_CNT_EN
    ,
    .LoadCnt   (LoadCnt),
    .StoreCnt  (StoreCnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic           rfwe;
    logic [AWL-2:0] rfa;
    logic [DWL-1:0] result;
    logic           err;
    int             due;
    string          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Drive one M-stage vector right after a rising edge; the next edge
  // captures it, so its W response is due in the following cycle.
  task automatic issue(input string tag, input logic rfwe, input logic sel,
                       input logic we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [AWL-2:0] rfa,
                       input logic e_rfwe, input logic [31:0] e_res,
                       input logic e_err);
    exp_t e;
    @(posedge CLK);
    #1;
    RFWEM     = rfwe;
    MtoRFSelM = sel;
    DMWEM     = we;
    ALUOutM   = addr;
    DMdinM    = din;
    RFAM      = rfa;
    e.rfwe   = e_rfwe;
    e.rfa    = rfa;
    e.result = e_res;
    e.err    = e_err;
    e.due    = cycle + 1;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic drive_nop();
    RFWEM     = 1'b0;
    MtoRFSelM = 1'b0;
    DMWEM     = 1'b0;
    ALUOutM   = '0;
    DMdinM    = '0;
    RFAM      = '0;
  endtask

  // Monitor: compare the W outputs against the entry due this cycle.
  always @(negedge CLK) begin
    if (RSTn && sb.size() > 0 && sb[0].due <= cycle) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, "_due"},    32'(mon_e.due),    32'(cycle));
      check({mon_e.tag, "_rfwe"},   32'(RFWEW),        32'(mon_e.rfwe));
      check({mon_e.tag, "_rfa"},    32'(RFAW),         32'(mon_e.rfa));
      check({mon_e.tag, "_result"}, ResultW,           mon_e.result);
      check({mon_e.tag, "_dmerr"},  32'(DMErr),        32'(mon_e.err));
    end
  end

  initial begin
    RSTn = 1'b0;
    drive_nop();
    #1;
    check("rst0_rfwe",   32'(RFWEW), 32'd0);
    check("rst0_rfa",    32'(RFAW),  32'd0);
    check("rst0_result", ResultW,    32'd0);
    check("rst0_dmerr",  32'(DMErr), 32'd0);
`ifdef DM_ACCESS_CNT_EN
    check("rst0_loadcnt",  LoadCnt,  32'd0);
    check("rst0_storecnt", StoreCnt, 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;

    //    tag          rfwe sel we  addr          din           rfa  e_rfwe e_result      e_err
    issue("st_10",     0,   0,  1,  32'h10,       32'hDEADBEEF, 0,   0,     32'h10,       0);
    issue("ld_10",     1,   1,  0,  32'h10,       32'h0,        5,   1,     32'hDEADBEEF, 0);
    issue("alu",       1,   0,  0,  32'h12345678, 32'h0,        3,   1,     32'h12345678, 0);
    issue("ld_10b",    1,   1,  0,  32'h10,       32'h0,        6,   1,     32'hDEADBEEF, 0);
    issue("st_20",     0,   0,  1,  32'h20,       32'hCAFEF00D, 0,   0,     32'h20,       0);
    issue("st_22_mis", 0,   0,  1,  32'h22,       32'h11111111, 0,   0,     32'h22,       1);
    issue("ld_20",     1,   1,  0,  32'h20,       32'h0,        7,   1,     32'hCAFEF00D, 1);
    issue("ld_21_mis", 1,   1,  0,  32'h21,       32'h0,        8,   0,     32'h0,        1);
    issue("st_100",    0,   0,  1,  32'h100,      32'hA5A50001, 0,   0,     32'h100,      1);
    issue("ld_0",      1,   1,  0,  32'h0,        32'h0,        9,   1,     32'hA5A50001, 1);
    issue("stld_10",   1,   1,  1,  32'h10,       32'h55,       10,  1,     32'hDEADBEEF, 1);
    issue("ld_10c",    1,   1,  0,  32'h10,       32'h0,        11,  1,     32'h55,       1);
    issue("nop",       0,   0,  0,  32'h0,        32'h0,        0,   0,     32'h0,        1);

`ifdef DM_ACCESS_CNT_EN
    // Aligned loads: ld_10, ld_10b, ld_20, ld_0, stld_10, ld_10c.
    // Aligned stores: st_10, st_20, st_100, stld_10.
    check("loadcnt",  LoadCnt,  32'd6);
    check("storecnt", StoreCnt, 32'd4);
`endif

    // Reset with a register-file write in flight.
    issue("alu_pre_rst", 1, 0, 0, 32'h77, 32'h0, 4, 1, 32'h77, 1);
    @(posedge CLK);
    #2;
    check("inflight_rfwe", 32'(RFWEW), 32'd1);
    RSTn = 1'b0;
    #1;
    check("arst_rfwe",   32'(RFWEW), 32'd0);
    check("arst_rfa",    32'(RFAW),  32'd0);
    check("arst_result", ResultW,    32'd0);
    check("arst_dmerr",  32'(DMErr), 32'd0);
`ifdef DM_ACCESS_CNT_EN
    check("arst_loadcnt",  LoadCnt,  32'd0);
    check("arst_storecnt", StoreCnt, 32'd0);
`endif
    sb.delete();
    drive_nop();
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;

    // Memory survives reset; error flag starts clean again.
    issue("ld_10_post", 1, 1, 0, 32'h10, 32'h0, 12, 1, 32'h55,       0);
    issue("ld_0_post",  1, 1, 0, 32'h0,  32'h0, 13, 1, 32'hA5A50001, 0);
    issue("nop_end",    0, 0, 0, 32'h0,  32'h0, 0,  0, 32'h0,        0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_memory_writeback

// File: doc/memory_writeback.md
# memory_writeback

Memory and writeback stage of the pipelined MIPS core. It is the downstream end of the Execute-stage M-register outputs (RFWEM, MtoRFSelM, DMWEM, ALUOutM, DMdinM, RFAM). It owns the data memory and the M/W pipeline register, and it drives the writeback result, write enable and destination back to the register file and to the Execute forwarding muxes. It also flags misaligned data accesses and, optionally, counts loads and stores.

## Interface
- AWL, 6, address width parameter shared with the pipeline; the data memory index is ALUOutM[AWL+1:2].
- DWL, 32, data word width.
- DEPTH, 2**AWL, number of data memory words.
- CLK  in  1  pipeline clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- RFWEM  in  1  register-file write enable from M.
- MtoRFSelM  in  1  1 = writeback selects memory data; 0 = writeback selects ALU result.
- DMWEM  in  1  data memory write enable (store).
- ALUOutM  in  DWL  byte address for loads and stores, or the ALU result.
- DMdinM  in  DWL  store data.
- RFAM  in  AWL-1  destination register.
- ResultW  out  DWL  writeback data.
- RFWEW  out  1  writeback enable.
- RFAW  out  AWL-1  writeback destination.
- DMErr  out  1  sticky misaligned-access flag.
- LoadCnt, StoreCnt  out  DWL  access counters; present only with DM_ACCESS_CNT_EN.

## Operation
- A load is any M cycle with MtoRFSelM=1.
- A store is any M cycle with DMWEM=1.
- Word index = ALUOutM[AWL+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Misaligned access = a load or store with ALUOutM[1:0] != 0.
- Store, aligned: mem[index] <= DMdinM on the rising CLK edge.
- Store, misaligned: memory is not written and DMErr sets.
- Load read is combinational from the array in M. The result is captured into the W register as ReadDataW.
- Load, misaligned: ReadDataW <= 0, RFWEW <= 0 (the register-file write is squashed), and DMErr sets.
- W register captures RFWEM (gated as above), MtoRFSelM, ALUOutM, ReadDataW and RFAM.
- ResultW = MtoRFSelW ? ReadDataW : ALUOutW (combinational from the W register).
- DMErr is sticky: once set, it clears only on reset.
- DMWEM=1 together with MtoRFSelM=1 is a store followed by a read of the same word in the same cycle. The read returns the pre-store contents.

## Timing
- Latency is 1 cycle from the M inputs to RFWEW/RFAW/ResultW.
- A store in cycle N followed by a load of the same word in cycle N+1 returns the new data. There is no bypass requirement.
- On reset assertion, asynchronously:
  - RFWEW=0, RFAW=0, ResultW=0, DMErr=0.
  - Internal W register fields are all 0.
  - LoadCnt=StoreCnt=0.
- The memory array is not reset; its contents are undefined until written.
- On reset mid-operation, the in-flight W entry is discarded. The first edge after RSTn rises captures fresh M inputs.
- No stall or flush inputs; the stage advances every cycle.

## Configuration
- Macro DM_ACCESS_CNT_EN.
- Defined:
  - LoadCnt increments on every aligned load and StoreCnt on every aligned store. Misaligned accesses are not counted.
  - Both counters saturate at 2**DWL-1.
  - Both counters reset to 0.
- Undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package pipeline_pkg holds:
  - width constants AWL, DWL and DEPTH;
  - the W register reset value (0);
  - the misalignment mask constant 2'b11.
- One sub-module, data_memory: DEPTH x DWL, synchronous write, asynchronous read, no reset. It is instantiated once.
- The W register and the writeback mux are inline.

## Test plan
- Reset asserted mid-run with RFWEM=1 in flight -> RFWEW, RFAW, ResultW and DMErr all read 0 immediately (asynchronously), with no clock edge required.
- Store DMdinM=0xDEADBEEF at ALUOutM=0x10, then load at 0x10 with RFAM=5 on the next cycle -> one cycle later ResultW=0xDEADBEEF, RFWEW=1, RFAW=5.
- ALU op with MtoRFSelM=0, ALUOutM=0x12345678, RFAM=3, RFWEM=1 -> next cycle ResultW=0x12345678, RFWEW=1, RFAW=3, and memory is unchanged.
- Store at 0x22 (misaligned) then load at 0x20 -> the old word is returned and DMErr=1 stays set. A misaligned load at 0x21 -> RFWEW=0, ResultW=0.
- Store at ALUOutM=0x100 with DEPTH=64 -> wraps to word 0; a load at 0x0 returns the stored data.
- With DM_ACCESS_CNT_EN: 3 aligned loads, 2 aligned stores and 1 misaligned load -> LoadCnt=3, StoreCnt=2.
